// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and the address decoder for mem_arbiter.
//   state_t       - transaction FSM states
//   region_t      - decoded target of an access
//   decode_region - maps a word address onto ROM / RAM / ILLEGAL given the
//                   ROM and RAM region sizes
package mem_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef enum logic [1:0] {REGION_ROM, REGION_RAM, REGION_ILLEGAL} region_t;

   // Decode is done at a fixed wide width so ROM_SIZE+RAM_SIZE can never
   // overflow whatever ADDR_W the instance uses (ADDR_W <= DECODE_W).
   localparam int DECODE_W = 64;

   function automatic region_t decode_region(input logic [DECODE_W-1:0] addr,
                                             input logic [DECODE_W-1:0] rom_size,
                                             input logic [DECODE_W-1:0] ram_size);
      if (addr < rom_size)
         return REGION_ROM;
      else if (addr < rom_size + ram_size)
         return REGION_RAM;
      return REGION_ILLEGAL;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requester out of NUM_PORTS.
//   MEM_ARBITER_RR_EN defined   - round robin; search starts one past the last
//                                 winner, pointer moves only when grant_en is
//                                 high and some port requests.
//   MEM_ARBITER_RR_EN undefined - fixed priority, highest index wins; no state.
// Ports:
//   clock, reset_n  clock / async active-low reset (round-robin build only)
//   req             per-port request
//   grant_en        grants may be issued this cycle
//   grant           one-hot grant (zero when grant_en is low or no request)
//   idx             encoded winner, valid whenever any req is high
module rr_arbiter #(
   parameter  int NUM_PORTS = 2,
   localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
`ifdef MEM_ARBITER_RR_EN
   input  logic                 clock,
   input  logic                 reset_n,
`endif
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 grant_en,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     idx
);

   logic found;

`ifdef MEM_ARBITER_RR_EN
   logic [IDX_W-1:0] ptr;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         if (!found && req[(int'(ptr) + k) % NUM_PORTS]) begin
            found = 1'b1;
            idx   = IDX_W'((int'(ptr) + k) % NUM_PORTS);
         end
      end
   end

   // Reset to the last port so port 0 is searched first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ptr <= IDX_W'(NUM_PORTS - 1);
      else if (grant_en && found)
         ptr <= idx;
   end
`else
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end
`endif

   assign grant = (grant_en && found) ? (NUM_PORTS'(1) << idx) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_PORTS requesters onto a shared ROM and RAM.
// Each granted access is decoded (ROM / RAM / ILLEGAL), RAM addresses are
// rebased to start at 0, and completion is signalled by a one-cycle ack.
// Build option: MEM_ARBITER_RR_EN selects round-robin arbitration; without it
// the highest-index requester always wins.
// Ports:
//   clock, reset_n       clock / async active-low reset
//   req, we              per-port request (held until ack) and write enable
//   addr, wdata          packed per-port address / write data
//   ack, err             one-hot completion pulse and illegal-access flag
//   rdata                read data, valid with ack
//   rom_rd, rom_addr     ROM read strobe and word address
//   rom_rdata            ROM read data
//   ram_rd, ram_wr       RAM strobes
//   ram_addr, ram_wdata  rebased RAM address and write data
//   ram_rdata            RAM read data
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter  int NUM_PORTS    = 2,
   parameter  int ADDR_W       = 32,
   parameter  int DATA_W       = 32,
   parameter  int ROM_SIZE     = 32,
   parameter  int RAM_SIZE     = 64,
   parameter  int READ_LATENCY = 1,
   localparam int IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int CNT_W        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS-1:0]        we,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr,
   input  logic [NUM_PORTS*DATA_W-1:0] wdata,
   output logic [NUM_PORTS-1:0]        ack,
   output logic [NUM_PORTS-1:0]        err,
   output logic [DATA_W-1:0]           rdata,
   output logic                        rom_rd,
   output logic [ADDR_W-1:0]           rom_addr,
   input  logic [DATA_W-1:0]           rom_rdata,
   output logic                        ram_rd,
   output logic                        ram_wr,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   input  logic [DATA_W-1:0]           ram_rdata
);

   state_t                state, state_nx;
   region_t               region_d, region_q;
   logic [NUM_PORTS-1:0]  grant;
   logic [IDX_W-1:0]      arb_idx, win_idx;
   logic [ADDR_W-1:0]     addr_sel;
   logic                  we_sel, we_q;
   logic [DATA_W-1:0]     wdata_sel, wdata_q, rdata_q;
   logic [ADDR_W-1:0]     rom_addr_q, ram_addr_q;
   logic [CNT_W-1:0]      cnt;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
`ifdef MEM_ARBITER_RR_EN
      .clock    (clock),
      .reset_n  (reset_n),
`endif
      .req      (req),
      .grant_en (state == IDLE),
      .grant    (grant),
      .idx      (arb_idx)
   );

   // Winner's request fields, only meaningful in IDLE while grant is high.
   assign addr_sel  = addr[arb_idx*ADDR_W +: ADDR_W];
   assign wdata_sel = wdata[arb_idx*DATA_W +: DATA_W];
   assign we_sel    = we[arb_idx];

   always_comb begin
      region_d = decode_region(DECODE_W'(addr_sel), DECODE_W'(ROM_SIZE), DECODE_W'(RAM_SIZE));
      if (we_sel && region_d == REGION_ROM)
         region_d = REGION_ILLEGAL;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|grant) state_nx = ISSUE;
         ISSUE:   state_nx = (region_q != REGION_ILLEGAL && !we_q) ? WAIT : RESP;
         WAIT:    if (cnt == CNT_W'(READ_LATENCY - 1)) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset as well (not just the FSM) so the
   // address, write-data and read-data outputs read 0 straight out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         win_idx    <= '0;
         we_q       <= 1'b0;
         region_q   <= REGION_ROM;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (|grant) begin
               win_idx    <= arb_idx;
               we_q       <= we_sel;
               region_q   <= region_d;
               rom_addr_q <= addr_sel;
               // Wraps for ROM/illegal addresses; only used when region is RAM.
               ram_addr_q <= addr_sel - ADDR_W'(ROM_SIZE);
               wdata_q    <= wdata_sel;
            end
            ISSUE: begin
               cnt     <= '0;
               rdata_q <= '0;   // writes and illegal reads return 0
            end
            WAIT: begin
               if (cnt == CNT_W'(READ_LATENCY - 1))
                  rdata_q <= (region_q == REGION_ROM) ? rom_rdata : ram_rdata;
               else
                  cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Strobes and ack decode straight from the state register, so reset
   // clears them asynchronously.
   assign rom_rd    = (state == ISSUE) && (region_q == REGION_ROM);
   assign ram_rd    = (state == ISSUE) && (region_q == REGION_RAM) && !we_q;
   assign ram_wr    = (state == ISSUE) && (region_q == REGION_RAM) && we_q;
   assign ack       = (state == RESP) ? (NUM_PORTS'(1) << win_idx) : '0;
   assign err       = (state == RESP && region_q == REGION_ILLEGAL) ? (NUM_PORTS'(1) << win_idx) : '0;
   assign rdata     = rdata_q;
   assign rom_addr  = rom_addr_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = wdata_q;

endmodule
